// File: rtl/control_unit_pipe.sv
// ID-stage control unit: decodes the instruction and registers the control bundle into ID/EX,
// inserting load-use bubbles and holding EX for multi-cycle M ops. Optional: CU_ILLEGAL_TRAP_EN.
module control_unit_pipe #(
   parameter int MUL_CYCLES = 1,
   parameter int DIV_CYCLES = 8,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       id_valid,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic [4:0] ex_rd,
   input  logic       stall_in,
   input  logic       flush,
   output logic       ex_valid,
   output logic [4:0] ex_alu_op,
   output logic       ex_reg_write_en,
   output logic [2:0] ex_mem_write,
   output logic [3:0] ex_mem_read,
   output logic [3:0] ex_branch_jump,
   output logic [3:0] ex_imm_sel,
   output logic       ex_data1_alu_sel,
   output logic       ex_data2_alu_sel,
   output logic [1:0] ex_wb_sel,
   output logic       ex_illegal,
   output logic       id_stall,
   output logic       md_busy
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam bit MUL_LONG = (MUL_CYCLES > 1);
   localparam bit DIV_LONG = (DIV_CYCLES > 1);

   typedef struct packed {
      logic       valid;
      logic       illegal;
      logic [4:0] alu_op;
      logic       reg_write_en;
      logic [2:0] mem_write;
      logic [3:0] mem_read;
      logic [3:0] branch_jump;
      logic [3:0] imm_sel;
      logic       data1_alu_sel;
      logic       data2_alu_sel;
      logic [1:0] wb_sel;
   } ctrl_t;

   typedef enum logic {IDLE, MD_WAIT} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   ctrl_t            ex_q;
   ctrl_t            dec_p0;
   ctrl_t            nxt_p0;

   logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, is_zero;
   logic is_m, alt_f7, uses_rs1, uses_rs2, luh, md_long;

   assign is_r      = (opcode == OP_R);
   assign is_i      = (opcode == OP_I);
   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_jal    = (opcode == OP_JAL);
   assign is_jalr   = (opcode == OP_JALR);
   assign is_lui    = (opcode == OP_LUI);
   assign is_auipc  = (opcode == OP_AUIPC);
   assign is_zero   = (opcode == 7'b0000000);
   assign is_m      = is_r && (funct7 == 7'b0000001);
   assign alt_f7    = (funct7 == 7'b0100000);

   assign uses_rs1 = !(is_lui || is_auipc || is_jal);
   assign uses_rs2 = is_r || is_store || is_branch;
   assign luh = ex_q.valid && ex_q.mem_read[3] && (ex_rd != 5'd0) && id_valid &&
                (((ex_rd == rs1) && uses_rs1) || ((ex_rd == rs2) && uses_rs2));
   assign md_long = is_m && (funct3[2] ? DIV_LONG : MUL_LONG);

   always_comb begin
      dec_p0 = '0;
      dec_p0.valid = 1'b1;
      dec_p0.alu_op[2:0] = (is_auipc || is_jal || is_store || is_load || is_branch) ? 3'b000 : funct3;
      dec_p0.alu_op[3] = is_m || is_lui;
      dec_p0.alu_op[4] = (is_r && alt_f7 && (funct3 == 3'b000 || funct3 == 3'b101)) ||
                         (is_i && alt_f7 && funct3 == 3'b101) || is_lui;
      dec_p0.reg_write_en = !(is_store || is_branch || is_zero);
      dec_p0.mem_write = {is_store, funct3[1:0]};
      dec_p0.mem_read = {is_load, funct3};
      dec_p0.branch_jump[3] = is_jal || is_jalr || is_branch;
      dec_p0.branch_jump[2:0] = (is_jal || is_jalr) ? 3'b010 : funct3;
      case (opcode)
         OP_LOAD, OP_JALR: dec_p0.imm_sel[2:0] = 3'd3;
         OP_I:             dec_p0.imm_sel[2:0] = (funct3[1:0] == 2'b01) ? 3'd6 : 3'd3;
         OP_AUIPC, OP_LUI: dec_p0.imm_sel[2:0] = 3'd1;
         OP_JAL:           dec_p0.imm_sel[2:0] = 3'd2;
         OP_BRANCH:        dec_p0.imm_sel[2:0] = 3'd4;
         OP_STORE:         dec_p0.imm_sel[2:0] = 3'd5;
         default:          dec_p0.imm_sel[2:0] = 3'd0;
      endcase
      // Unsigned variants: LBU/LHU, SLTIU, SLTU, MULHSU/MULHU/REMU.
      dec_p0.imm_sel[3] = (is_load && (funct3 == 3'b100 || funct3 == 3'b101)) ||
                          (is_i && funct3 == 3'b011) ||
                          (is_r && funct7 == 7'b0000000 && funct3 == 3'b011) ||
                          (is_m && (funct3 == 3'b010 || funct3 == 3'b011 || funct3 == 3'b111));
      dec_p0.data1_alu_sel = is_auipc || is_jal || is_jalr || is_branch;
      dec_p0.data2_alu_sel = !is_r;
      dec_p0.wb_sel[0] = !(is_load || is_lui);
      dec_p0.wb_sel[1] = is_lui || is_jal || is_jalr;

      nxt_p0 = '0;
      if (id_valid) begin
`ifdef CU_ILLEGAL_TRAP_EN
         if (!(is_r || is_i || is_load || is_store || is_branch || is_jal || is_jalr ||
               is_lui || is_auipc || is_zero)) begin
            nxt_p0.valid   = 1'b1;
            nxt_p0.illegal = 1'b1;
         end else begin
            nxt_p0 = dec_p0;
         end
`else
         nxt_p0 = dec_p0;
`endif
      end
   end

   always_comb begin
      id_stall = 1'b0;
      if (reset) begin
         if (stall_in)
            id_stall = 1'b1;
         else if (!flush)
            id_stall = (state == MD_WAIT) || luh;
      end
   end

   // ID/EX boundary
   always_ff @(posedge clk) begin
      if (!reset) begin
         ex_q    <= '0;
         state   <= IDLE;
         cnt     <= '0;
         md_busy <= 1'b0;
      end else if (!stall_in) begin
         if (flush) begin
            ex_q    <= '0;
            state   <= IDLE;
            cnt     <= '0;
            md_busy <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (luh) begin
                     ex_q <= '0;
                  end else begin
                     ex_q <= nxt_p0;
                     if (id_valid && md_long) begin
                        cnt     <= funct3[2] ? DIV_LOAD : MUL_LOAD;
                        state   <= MD_WAIT;
                        md_busy <= 1'b1;
                     end
                  end
               end
               MD_WAIT: begin
                  cnt <= cnt - 1'b1;
                  if (cnt <= CNT_ONE) begin
                     cnt     <= '0;
                     state   <= IDLE;
                     md_busy <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign ex_valid         = ex_q.valid;
   assign ex_illegal       = ex_q.illegal;
   assign ex_alu_op        = ex_q.alu_op;
   assign ex_reg_write_en  = ex_q.reg_write_en;
   assign ex_mem_write     = ex_q.mem_write;
   assign ex_mem_read      = ex_q.mem_read;
   assign ex_branch_jump   = ex_q.branch_jump;
   assign ex_imm_sel       = ex_q.imm_sel;
   assign ex_data1_alu_sel = ex_q.data1_alu_sel;
   assign ex_data2_alu_sel = ex_q.data2_alu_sel;
   assign ex_wb_sel        = ex_q.wb_sel;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Directed bench for control_unit_pipe: decode table, load-use bubble, M-op occupancy,
// flush/stall priority and the CU_ILLEGAL_TRAP_EN illegal-opcode path.
module tb_control_unit_pipe;

   logic       clk = 1'b0;
   logic       reset, id_valid, stall_in, flush;
   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic [4:0] rs1, rs2, ex_rd;
   logic       ex_valid, ex_reg_write_en, ex_data1_alu_sel, ex_data2_alu_sel, ex_illegal;
   logic       id_stall, md_busy;
   logic [4:0] ex_alu_op;
   logic [2:0] ex_mem_write;
   logic [3:0] ex_mem_read, ex_branch_jump, ex_imm_sel;
   logic [1:0] ex_wb_sel;
   logic [26:0] act;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   control_unit_pipe #(.MUL_CYCLES(1), .DIV_CYCLES(8), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode), .funct3(funct3),
      .funct7(funct7), .rs1(rs1), .rs2(rs2), .ex_rd(ex_rd), .stall_in(stall_in), .flush(flush),
      .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_reg_write_en(ex_reg_write_en),
      .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read), .ex_branch_jump(ex_branch_jump),
      .ex_imm_sel(ex_imm_sel), .ex_data1_alu_sel(ex_data1_alu_sel),
      .ex_data2_alu_sel(ex_data2_alu_sel), .ex_wb_sel(ex_wb_sel), .ex_illegal(ex_illegal),
      .id_stall(id_stall), .md_busy(md_busy)
   );

   assign act = {ex_valid, ex_illegal, ex_alu_op, ex_reg_write_en, ex_mem_write, ex_mem_read,
                 ex_branch_jump, ex_imm_sel, ex_data1_alu_sel, ex_data2_alu_sel, ex_wb_sel};

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        v;
      logic [26:0] exp;
   } vec_t;

   vec_t vec [16];

   function automatic logic [26:0] eb(input logic v, input logic il, input logic [4:0] alu,
                                      input logic rw, input logic [2:0] mw, input logic [3:0] mr,
                                      input logic [3:0] bj, input logic [3:0] imm,
                                      input logic d1, input logic d2, input logic [1:0] wb);
      return {v, il, alu, rw, mw, mr, bj, imm, d1, d2, wb};
   endfunction

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] r1, input logic [4:0] r2);
      id_valid = 1'b1;
      opcode = op; funct3 = f3; funct7 = f7; rs1 = r1; rs2 = r2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [26:0] b_add, b_div, b_mul, b_ill;
      int n, busy_n, stall_n;

      b_add = eb(1, 0, 5'b00000, 1, 3'b000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'b01);
      b_div = eb(1, 0, 5'b01100, 1, 3'b000, 4'b0100, 4'b0100, 4'b0000, 0, 0, 2'b01);
      b_mul = eb(1, 0, 5'b01000, 1, 3'b000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'b01);
`ifdef CU_ILLEGAL_TRAP_EN
      b_ill = eb(1, 1, 5'b00000, 0, 3'b000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'b00);
`else
      b_ill = eb(1, 0, 5'b00000, 1, 3'b000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 2'b01);
`endif

      vec[0]  = '{7'b0110011, 3'b000, 7'b0000000, 1, b_add};
      vec[1]  = '{7'b0110011, 3'b000, 7'b0100000, 1, eb(1,0,5'b10000,1,3'b000,4'b0000,4'b0000,4'b0000,0,0,2'b01)};
      vec[2]  = '{7'b0110011, 3'b011, 7'b0000000, 1, eb(1,0,5'b00011,1,3'b011,4'b0011,4'b0011,4'b1000,0,0,2'b01)};
      vec[3]  = '{7'b0110011, 3'b011, 7'b0000001, 1, eb(1,0,5'b01011,1,3'b011,4'b0011,4'b0011,4'b1000,0,0,2'b01)};
      vec[4]  = '{7'b0010011, 3'b101, 7'b0100000, 1, eb(1,0,5'b10101,1,3'b001,4'b0101,4'b0101,4'b0110,0,1,2'b01)};
      vec[5]  = '{7'b0010011, 3'b011, 7'b0000000, 1, eb(1,0,5'b00011,1,3'b011,4'b0011,4'b0011,4'b1011,0,1,2'b01)};
      vec[6]  = '{7'b0000011, 3'b100, 7'b0000000, 1, eb(1,0,5'b00000,1,3'b000,4'b1100,4'b0100,4'b1011,0,1,2'b00)};
      vec[7]  = '{7'b0100011, 3'b010, 7'b0000000, 1, eb(1,0,5'b00000,0,3'b110,4'b0010,4'b0010,4'b0101,0,1,2'b01)};
      vec[8]  = '{7'b1100011, 3'b001, 7'b0000000, 1, eb(1,0,5'b00000,0,3'b001,4'b0001,4'b1001,4'b0100,1,1,2'b01)};
      vec[9]  = '{7'b1101111, 3'b011, 7'b0000000, 1, eb(1,0,5'b00000,1,3'b011,4'b0011,4'b1010,4'b0010,1,1,2'b11)};
      vec[10] = '{7'b1100111, 3'b000, 7'b0000000, 1, eb(1,0,5'b00000,1,3'b000,4'b0000,4'b1010,4'b0011,1,1,2'b11)};
      vec[11] = '{7'b0110111, 3'b101, 7'b0000000, 1, eb(1,0,5'b11101,1,3'b001,4'b0101,4'b0101,4'b0001,0,1,2'b10)};
      vec[12] = '{7'b0010111, 3'b110, 7'b0000000, 1, eb(1,0,5'b00000,1,3'b010,4'b0110,4'b0110,4'b0001,1,1,2'b01)};
      vec[13] = '{7'b0000000, 3'b000, 7'b0000000, 1, eb(1,0,5'b00000,0,3'b000,4'b0000,4'b0000,4'b0000,0,1,2'b01)};
      vec[14] = '{7'b0110011, 3'b000, 7'b0000000, 0, 27'd0};
      vec[15] = '{7'b1111111, 3'b000, 7'b0000000, 1, b_ill};

      // Reset held low with ADD presented, stall_in also high in the second cycle
      reset = 1'b0; stall_in = 1'b0; flush = 1'b0; ex_rd = 5'd0;
      instr(7'b0110011, 3'b000, 7'b0000000, 5'd1, 5'd2);
      tick();
      stall_in = 1'b1;
      tick();
      chk("rst_bundle", 32'(act), 32'd0);
      chk("rst_stall", 32'(id_stall), 32'd0);
      chk("rst_busy", 32'(md_busy), 32'd0);
      stall_in = 1'b0;
      reset = 1'b1;
      tick();
      chk("rst_first_add", 32'(act), 32'(b_add));

      for (int i = 0; i < 16; i++) begin
         id_valid = vec[i].v;
         opcode = vec[i].op; funct3 = vec[i].f3; funct7 = vec[i].f7;
         rs1 = 5'd1; rs2 = 5'd2;
         tick();
         total++;
         if (act !== vec[i].exp) begin
            bad++;
            $display("FAIL dec[%0d]: got 0x%0h expected 0x%0h", i, act, vec[i].exp);
         end
      end
      chk("dec_stall", 32'(id_stall), 32'd0);

      // Load-use on rs1: one bubble then ADD issues
      instr(7'b0000011, 3'b010, 7'b0, 5'd3, 5'd0);
      tick();
      ex_rd = 5'd5;
      instr(7'b0110011, 3'b000, 7'b0, 5'd5, 5'd1);
      #1 chk("luh_stall", 32'(id_stall), 32'd1);
      tick();
      chk("luh_bubble", 32'(act), 32'd0);
      chk("luh_clear", 32'(id_stall), 32'd0);
      tick();
      chk("luh_issue", 32'(act), 32'(b_add));

      // Load-use on rs2 (store data)
      ex_rd = 5'd0;
      instr(7'b0000011, 3'b010, 7'b0, 5'd3, 5'd0);
      tick();
      ex_rd = 5'd5;
      instr(7'b0100011, 3'b010, 7'b0, 5'd2, 5'd5);
      #1 chk("luh_rs2", 32'(id_stall), 32'd1);
      tick();
      tick();

      // LUI does not read rs1: no bubble even when the field matches
      ex_rd = 5'd0;
      instr(7'b0000011, 3'b010, 7'b0, 5'd3, 5'd0);
      tick();
      ex_rd = 5'd5;
      instr(7'b0110111, 3'b000, 7'b0, 5'd5, 5'd5);
      #1 chk("luh_lui", 32'(id_stall), 32'd0);
      tick();

      // Load to x0 never causes a bubble
      ex_rd = 5'd0;
      instr(7'b0000011, 3'b010, 7'b0, 5'd3, 5'd0);
      tick();
      instr(7'b0110011, 3'b000, 7'b0, 5'd0, 5'd0);
      #1 chk("luh_x0_stall", 32'(id_stall), 32'd0);
      tick();
      chk("luh_x0_issue", 32'(act), 32'(b_add));

      // DIV occupies EX for 8 cycles, ADD follows on cycle 9
      instr(7'b0110011, 3'b100, 7'b0000001, 5'd1, 5'd2);
      tick();
      instr(7'b0110011, 3'b000, 7'b0, 5'd1, 5'd2);
      busy_n = 0; stall_n = 0;
      for (int k = 1; k <= 8; k++) begin
         #1;
         if (act !== b_div) begin
            total++; bad++;
            $display("FAIL div_hold[%0d]: got 0x%0h expected 0x%0h", k, act, b_div);
         end else begin
            total++;
         end
         if (md_busy) busy_n++;
         if (id_stall) stall_n++;
         tick();
      end
      chk("div_next", 32'(act), 32'(b_add));
      chk("div_busy_cycles", 32'(busy_n), 32'd7);
      chk("div_stall_cycles", 32'(stall_n), 32'd7);

      // MUL with MUL_CYCLES=1 flows back-to-back
      instr(7'b0110011, 3'b000, 7'b0000001, 5'd1, 5'd2);
      tick();
      chk("mul_issue", 32'(act), 32'(b_mul));
      instr(7'b0110011, 3'b000, 7'b0, 5'd1, 5'd2);
      #1 chk("mul_no_stall", 32'(id_stall), 32'd0);
      chk("mul_no_busy", 32'(md_busy), 32'd0);
      tick();
      chk("mul_next", 32'(act), 32'(b_add));

      // Flush on the 3rd MD_WAIT cycle
      instr(7'b0110011, 3'b100, 7'b0000001, 5'd1, 5'd2);
      tick();
      instr(7'b0110011, 3'b000, 7'b0, 5'd1, 5'd2);
      tick();
      tick();
      flush = 1'b1;
      #1 chk("flush_stall", 32'(id_stall), 32'd0);
      tick();
      flush = 1'b0;
      chk("flush_nop", 32'(act), 32'd0);
      chk("flush_busy", 32'(md_busy), 32'd0);
      #1 chk("flush_idle", 32'(id_stall), 32'd0);
      tick();
      chk("flush_next", 32'(act), 32'(b_add));

      // stall_in beats flush: state frozen, then DIV finishes its 7 wait cycles
      instr(7'b0110011, 3'b100, 7'b0000001, 5'd1, 5'd2);
      tick();
      instr(7'b0110011, 3'b000, 7'b0, 5'd1, 5'd2);
      stall_in = 1'b1; flush = 1'b1;
      #1 chk("sf_stall", 32'(id_stall), 32'd1);
      tick();
      tick();
      chk("sf_hold", 32'(act), 32'(b_div));
      chk("sf_busy", 32'(md_busy), 32'd1);
      stall_in = 1'b0; flush = 1'b0;
      n = 0;
      while (md_busy && n < 20) begin
         n++;
         tick();
      end
      chk("sf_remaining", 32'(n), 32'd7);
      tick();
      chk("sf_next", 32'(act), 32'(b_add));

      // stall_in for 3 cycles with counter at 5
      instr(7'b0110011, 3'b100, 7'b0000001, 5'd1, 5'd2);
      tick();
      instr(7'b0110011, 3'b000, 7'b0, 5'd1, 5'd2);
      tick();
      tick();
      stall_in = 1'b1;
      tick();
      tick();
      tick();
      chk("st_busy", 32'(md_busy), 32'd1);
      chk("st_hold", 32'(act), 32'(b_div));
      stall_in = 1'b0;
      n = 0;
      while (md_busy && n < 20) begin
         n++;
         tick();
      end
      chk("st_remaining", 32'(n), 32'd5);
      chk("st_last_hold", 32'(act), 32'(b_div));
      chk("st_idle_stall", 32'(id_stall), 32'd0);
      tick();
      chk("st_next", 32'(act), 32'(b_add));

      // Illegal opcode, then cleared by flush
      instr(7'b1111111, 3'b000, 7'b0, 5'd1, 5'd2);
      tick();
      chk("ill_bundle", 32'(act), 32'(b_ill));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("ill_flush", 32'(ex_illegal), 32'd0);

      id_valid = 1'b0;
      tick();
      chk("idle_nop", 32'(act), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
